// File: rtl/hp_keypad_if.sv
// Key-matrix / core-side signal bundle for hp_keypad_scanner.
// KEY_SIM_INJECT_EN adds the simulator key-injection pair.
interface hp_keypad_if #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 5
);
    logic [COLS-1:0] col_drive_n_o;
    logic [ROWS-1:0] row_sense_n_in;
    logic            key_ack_in;
    logic            key_pending_o;
    logic [7:0]      keycode_o;
    logic            key_down_o;
`ifdef KEY_SIM_INJECT_EN
    logic            simkey_activate_key_pending_in;
    logic [7:0]      simkey_keycode_in;

    modport master (
        output col_drive_n_o, key_pending_o, keycode_o, key_down_o,
        input  row_sense_n_in, key_ack_in,
        input  simkey_activate_key_pending_in, simkey_keycode_in
    );
    modport slave (
        input  col_drive_n_o, key_pending_o, keycode_o, key_down_o,
        output row_sense_n_in, key_ack_in,
        output simkey_activate_key_pending_in, simkey_keycode_in
    );
`else
    modport master (
        output col_drive_n_o, key_pending_o, keycode_o, key_down_o,
        input  row_sense_n_in, key_ack_in
    );
    modport slave (
        input  col_drive_n_o, key_pending_o, keycode_o, key_down_o,
        output row_sense_n_in, key_ack_in
    );
`endif
endinterface

// File: rtl/hp_keypad_scanner.sv
// Scans and debounces a ROWS x COLS key matrix, reporting each press once as keycode/pending.
// Optional KEY_SIM_INJECT_EN adds a simulator injection path that overrides the matrix.
module hp_keypad_scanner #(
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 5,
    parameter int unsigned SCAN_DIV       = 2080,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input logic        clk_in,
    input logic        rst_n_in,
    hp_keypad_if.master bus
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

    state_e           state_q, state_d;
    logic [ROWS-1:0]  row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       col_q, col_d;
    logic [COLS-1:0]  drive_q, drive_d;
    logic             acc_hit_q, acc_hit_d;
    logic [7:0]       acc_code_q, acc_code_d;
    logic [7:0]       key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [7:0]       keycode_q, keycode_d;
    logic             down_q, down_d;
`ifdef KEY_SIM_INJECT_EN
    logic             sim_act_q;
`endif

    logic       sample_c, scan_done_c, row_hit_c, scan_hit_c, accept_c;
    logic [3:0] row_idx_c;
    logic [7:0] scan_code_c;

    // Lowest closed row in the currently driven column.
    always_comb begin
        row_hit_c = 1'b0;
        row_idx_c = '0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                row_hit_c = 1'b1;
                row_idx_c = 4'(r);
            end
        end
    end

    always_comb begin
        sample_c    = (div_q == DIV_W'(SCAN_DIV - 1));
        scan_done_c = sample_c && (col_q == 4'(COLS - 1));
        // Earlier columns take priority over the column sampled now.
        scan_hit_c  = acc_hit_q || (sample_c && row_hit_c);
        scan_code_c = acc_hit_q ? acc_code_q : {row_idx_c, col_q};

        div_d      = div_q + 1'b1;
        col_d      = col_q;
        drive_d    = drive_q;
        acc_hit_d  = acc_hit_q;
        acc_code_d = acc_code_q;
        if (sample_c) begin
            div_d   = '0;
            col_d   = scan_done_c ? 4'd0 : col_q + 4'd1;
            drive_d = ~(COLS'(1) << col_d);
            if (scan_done_c) begin
                acc_hit_d  = 1'b0;
                acc_code_d = '0;
            end else if (!acc_hit_q && row_hit_c) begin
                acc_hit_d  = 1'b1;
                acc_code_d = {row_idx_c, col_q};
            end
        end

        state_d  = state_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        down_d   = down_q;
        accept_c = 1'b0;
        if (scan_done_c) begin
            unique case (state_q)
                SCAN: begin
                    if (scan_hit_c) begin
                        key_d = scan_code_c;
                        if (DEBOUNCE_SCANS <= 1) begin
                            accept_c = 1'b1;
                            state_d  = HELD;
                            cnt_d    = '0;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (scan_hit_c && scan_code_c == key_q) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            accept_c = 1'b1;
                            state_d  = HELD;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (scan_hit_c) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                        down_d  = 1'b0;
                        state_d = SCAN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end
        if (accept_c) down_d = 1'b1;

        // Accept overrides a same-edge ack; injection overrides both.
        pending_d = pending_q;
        keycode_d = keycode_q;
        if (bus.key_ack_in) pending_d = 1'b0;
        if (accept_c) begin
            pending_d = 1'b1;
            keycode_d = scan_code_c;
        end
`ifdef KEY_SIM_INJECT_EN
        if (bus.simkey_activate_key_pending_in && !sim_act_q) begin
            pending_d = 1'b1;
            keycode_d = bus.simkey_keycode_in;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= SCAN;
            row_meta_q <= '1;
            row_sync_q <= '1;
            div_q      <= '0;
            col_q      <= '0;
            drive_q    <= ~COLS'(1);
            acc_hit_q  <= 1'b0;
            acc_code_q <= '0;
            key_q      <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            keycode_q  <= '0;
            down_q     <= 1'b0;
`ifdef KEY_SIM_INJECT_EN
            sim_act_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_meta_q <= bus.row_sense_n_in;
            row_sync_q <= row_meta_q;
            div_q      <= div_d;
            col_q      <= col_d;
            drive_q    <= drive_d;
            acc_hit_q  <= acc_hit_d;
            acc_code_q <= acc_code_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            keycode_q  <= keycode_d;
            down_q     <= down_d;
`ifdef KEY_SIM_INJECT_EN
            sim_act_q  <= bus.simkey_activate_key_pending_in;
`endif
        end
    end

    assign bus.col_drive_n_o = drive_q;
    assign bus.key_pending_o = pending_q;
    assign bus.keycode_o     = keycode_q;
    assign bus.key_down_o    = down_q;
endmodule

// File: tb/tb_hp_keypad_scanner.sv
// Self-checking bench for hp_keypad_scanner: matrix model, press table and keycode scoreboard.
module tb_hp_keypad_scanner;
    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic [ROWS*COLS-1:0] keys;
    logic [ROWS-1:0] row_n;

    hp_keypad_if #(.ROWS(ROWS), .COLS(COLS)) bus();

    hp_keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Switch matrix: a closed switch pulls its row low while its column is driven.
    always_comb begin
        for (int r = 0; r < int'(ROWS); r++) begin
            row_n[r] = 1'b1;
            for (int c = 0; c < int'(COLS); c++)
                if (keys[r*COLS + c] && !bus.col_drive_n_o[c]) row_n[r] = 1'b0;
        end
    end
    assign bus.row_sense_n_in = row_n;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int rise_cnt = 0;
    logic [7:0] exp_q[$];
    logic prev_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every new pending must match the oldest expected keycode.
    always @(negedge clk) begin
        logic [8:0] exp_code;
        if (bus.key_pending_o && !prev_pend) begin
            rise_cnt++;
            exp_code = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            check("sb_keycode", 32'({1'b0, bus.keycode_o}), 32'(exp_code));
        end
        prev_pend = bus.key_pending_o;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pend(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.key_pending_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_up(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.key_down_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_ack(input string name);
        bus.key_ack_in = 1'b1;
        tick(1);
        bus.key_ack_in = 1'b0;
        check(name, 32'(bus.key_pending_o), 32'(0));
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        keys[r*COLS + c] = v;
    endtask

    task automatic release_all(input string name);
        bit ok;
        keys = '0;
        tick(35);
        check({name, "_down_held"}, 32'(bus.key_down_o), 32'(1));
        wait_up(70, ok);
        check({name, "_released"}, 32'(ok), 32'(1));
        tick(5);
    endtask

    typedef struct {
        int         row;
        int         col;
        logic [7:0] code;
    } press_t;

    press_t vec[5];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int rc0;
        vec[0] = '{row: 1, col: 4, code: 8'h14};
        vec[1] = '{row: 0, col: 0, code: 8'h00};
        vec[2] = '{row: 7, col: 4, code: 8'h74};
        vec[3] = '{row: 5, col: 2, code: 8'h52};
        vec[4] = '{row: 3, col: 1, code: 8'h31};

        rst_n = 1'b0;
        keys = '0;
        bus.key_ack_in = 1'b0;
`ifdef KEY_SIM_INJECT_EN
        bus.simkey_activate_key_pending_in = 1'b0;
        bus.simkey_keycode_in = 8'h00;
`endif
        // Reset state and column rotation/wrap
        tick(3);
        check("rst_col", 32'(bus.col_drive_n_o), 32'(5'b11110));
        check("rst_pending", 32'(bus.key_pending_o), 32'(0));
        check("rst_keycode", 32'(bus.keycode_o), 32'(0));
        check("rst_down", 32'(bus.key_down_o), 32'(0));
        rst_n = 1'b1;
        tick(3);
        check("col0_window", 32'(bus.col_drive_n_o), 32'(5'b11110));
        tick(1);
        check("col1", 32'(bus.col_drive_n_o), 32'(5'b11101));
        tick(12);
        check("col4", 32'(bus.col_drive_n_o), 32'(5'b01111));
        tick(4);
        check("col_wrap", 32'(bus.col_drive_n_o), 32'(5'b11110));

        // Ack with nothing pending is ignored
        do_ack("idle_ack");
        check("idle_keycode", 32'(bus.keycode_o), 32'(0));

        // Table of clean single presses
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vec[i].code);
            set_key(vec[i].row, vec[i].col, 1'b1);
            wait_pend(83, ok);
            check("press_latency", 32'(ok), 32'(1));
            if (!ok) exp_q.delete();
            check("press_down", 32'(bus.key_down_o), 32'(1));
            do_ack("press_ack");
            check("keycode_hold", 32'(bus.keycode_o), 32'(vec[i].code));
            release_all("press");
        end

        // Bouncing contact: nothing accepted until it settles
        rc0 = rise_cnt;
        for (int i = 0; i < 8; i++) begin
            set_key(2, 3, (i % 2) == 0);
            tick(15);
        end
        check("bounce_no_pending", 32'(rise_cnt), 32'(rc0));
        exp_q.push_back(8'h23);
        set_key(2, 3, 1'b1);
        wait_pend(83, ok);
        check("bounce_accept", 32'(ok), 32'(1));
        if (!ok) exp_q.delete();
        tick(100);
        check("bounce_single", 32'(rise_cnt), 32'(rc0 + 1));
        do_ack("bounce_ack");
        release_all("bounce");

        // Two keys: lower column wins; partial release does not re-trigger
        rc0 = rise_cnt;
        exp_q.push_back(8'h31);
        set_key(3, 1, 1'b1);
        set_key(0, 2, 1'b1);
        wait_pend(83, ok);
        check("two_accept", 32'(ok), 32'(1));
        if (!ok) exp_q.delete();
        do_ack("two_ack");
        set_key(3, 1, 1'b0);
        tick(120);
        check("two_partial_down", 32'(bus.key_down_o), 32'(1));
        check("two_partial_no_pend", 32'(rise_cnt), 32'(rc0 + 1));
        release_all("two");
        check("two_total", 32'(rise_cnt), 32'(rc0 + 1));

        // Reset while debouncing discards the press; it is re-debounced afterwards
        set_key(1, 4, 1'b1);
        tick(25);
        rst_n = 1'b0;
        tick(2);
        check("mid_rst_pending", 32'(bus.key_pending_o), 32'(0));
        check("mid_rst_down", 32'(bus.key_down_o), 32'(0));
        check("mid_rst_col", 32'(bus.col_drive_n_o), 32'(5'b11110));
        rst_n = 1'b1;
        tick(50);
        check("redeb_not_early", 32'(bus.key_pending_o), 32'(0));
        exp_q.push_back(8'h14);
        wait_pend(40, ok);
        check("redeb_accept", 32'(ok), 32'(1));
        if (!ok) exp_q.delete();
        do_ack("redeb_ack");
        release_all("redeb");

`ifdef KEY_SIM_INJECT_EN
        // Simulator injection
        exp_q.push_back(8'h2B);
        bus.simkey_keycode_in = 8'h2B;
        bus.simkey_activate_key_pending_in = 1'b1;
        tick(1);
        check("inj_pending", 32'(bus.key_pending_o), 32'(1));
        check("inj_keycode", 32'(bus.keycode_o), 32'(8'h2B));
        tick(2);
        bus.simkey_activate_key_pending_in = 1'b0;
        do_ack("inj_ack");
        tick(3);
        check("inj_no_retrigger", 32'(bus.key_pending_o), 32'(0));
`endif

        check("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
